// File: rtl/booth_multiplier.sv
// Sequential signed 16x16 -> 32-bit multiplier, radix-2 Booth recoding,
// one recoding step per clock. A controller FSM (IDLE/CALC/DONE) sequences
// a datapath built from accumulator A, multiplier shift register Q, the
// Booth history bit q_1, the multiplicand register M and a step counter.
module booth_multiplier (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] in1,
    input  logic signed [15:0] in2,
    input  logic               start,
    output logic signed [31:0] out,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Datapath state. A carries one guard bit so that A - M cannot overflow
    // when the multiplicand is -32768.
    logic signed [16:0] a_q,   a_d;
    logic        [15:0] q_q,   q_d;
    logic               q1_q,  q1_d;
    logic signed [16:0] m_q,   m_d;
    logic        [4:0]  cnt_q, cnt_d;
    logic signed [31:0] out_q, out_d;
    logic               done_q, done_d;

    // Controller outputs steering the datapath.
    logic load_op;
    logic step_en;
    logic last_step;

    // Result of one Booth step applied to the current {A,Q,q_1}.
    logic [33:0] step_res;

    // One Booth recoding step: add/subtract M according to {Q[0],q_1}, then
    // arithmetic-shift the concatenation {A,Q,q_1} right by one.
    // Packing of the return value: [33:17] = A, [16:1] = Q, [0] = q_1.
    function automatic logic [33:0] booth_step(
        input logic signed [16:0] a,
        input logic        [15:0] q,
        input logic               q1,
        input logic signed [16:0] m
    );
        logic signed [16:0] sum;
        case ({q[0], q1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
        return {sum[16], sum, q};
    endfunction

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Controller next-state logic; start is only honoured outside CALC.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == 5'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_CALC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Controller outputs: operand load, per-cycle step, final step.
    always_comb begin
        load_op   = 1'b0;
        step_en   = 1'b0;
        last_step = 1'b0;
        case (state_q)
            S_IDLE:  load_op = start;
            S_DONE:  load_op = start;
            S_CALC: begin
                step_en   = 1'b1;
                last_step = (cnt_q == 5'd1);
            end
            default: begin
                load_op = 1'b0;
            end
        endcase
    end

    // Datapath next-state: capture operands, iterate, publish the product.
    always_comb begin
        a_d      = a_q;
        q_d      = q_q;
        q1_d     = q1_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        done_d   = done_q;
        step_res = booth_step(a_q, q_q, q1_q, m_q);
        if (load_op) begin
            a_d    = 17'sd0;
            q_d    = in2;
            q1_d   = 1'b0;
            m_d    = {in1[15], in1};
            cnt_d  = 5'd16;
            done_d = 1'b0;
        end else if (step_en) begin
            a_d   = step_res[33:17];
            q_d   = step_res[16:1];
            q1_d  = step_res[0];
            cnt_d = cnt_q - 5'd1;
            if (last_step) begin
                // Product is the low 16 bits of A followed by Q, post-shift.
                out_d  = {step_res[32:17], step_res[16:1]};
                done_d = 1'b1;
            end
        end
    end

    // Datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= 17'sd0;
            q_q    <= 16'd0;
            q1_q   <= 1'b0;
            m_q    <= 17'sd0;
            cnt_q  <= 5'd0;
            out_q  <= 32'sd0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            q_q    <= q_d;
            q1_q   <= q1_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            done_q <= done_d;
        end
    end

    assign out  = out_q;
    assign done = done_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed vectors, signed and
// boundary operands, robustness scenarios and a random sweep.
module tb_booth_multiplier;

    logic               clk;
    logic               rst;
    logic signed [15:0] in1;
    logic signed [15:0] in2;
    logic               start;
    logic signed [31:0] out;
    logic               done;

    int checks;
    int errors;

    booth_multiplier dut (
        .clk   (clk),
        .rst   (rst),
        .in1   (in1),
        .in2   (in2),
        .start (start),
        .out   (out),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // Launch one operation and wait (bounded) for done; no checking here.
    task automatic do_op(input logic signed [15:0] a, input logic signed [15:0] b,
                         output logic signed [31:0] p, output int lat);
        @(negedge clk);
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        p = out;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        in1   = 16'sd0;
        in2   = 16'sd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out !== 32'sd0) begin
            errors++;
            $display("FAIL reset_out: got %0d expected 0", out);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic signed [15:0] av [3] = '{16'sd0, 16'sd5, 16'sd12};
        logic signed [15:0] bv [3] = '{16'sd0, 16'sd3, 16'sd15};
        logic signed [31:0] ev [3] = '{32'sd0, 32'sd15, 32'sd180};
        logic signed [31:0] p;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], bv[i], p, lat);
            checks++;
            if (p !== ev[i]) begin
                errors++;
                $display("FAIL basic[%0d]: out=%0d expected=%0d", i, p, ev[i]);
            end
            checks++;
            if (lat !== 16) begin
                errors++;
                $display("FAIL basic_latency[%0d]: got %0d expected 16", i, lat);
            end
        end
    endtask

    task automatic test_signed();
        logic signed [15:0] av [4] = '{-16'sd5, 16'sd5, -16'sd5, -16'sd50};
        logic signed [15:0] bv [4] = '{16'sd3, -16'sd3, -16'sd3, -16'sd78};
        logic signed [31:0] ev [4] = '{-32'sd15, -32'sd15, 32'sd15, 32'sd3900};
        logic signed [31:0] p;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(av[i], bv[i], p, lat);
            checks++;
            if (p !== ev[i]) begin
                errors++;
                $display("FAIL signed[%0d]: out=%0d expected=%0d", i, p, ev[i]);
            end
            checks++;
            if (lat !== 16) begin
                errors++;
                $display("FAIL signed_latency[%0d]: got %0d expected 16", i, lat);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out !== 32'sd3900 || done !== 1'b1) begin
            errors++;
            $display("FAIL signed_hold: out=%0d done=%b expected 3900 and 1", out, done);
        end
    endtask

    task automatic test_edges();
        logic signed [15:0] av [8] = '{16'sd32767, 16'sd32767, 16'sd1, 16'sh8000,
                                       -16'sd1, 16'sh8000, 16'sh8000, 16'sd2};
        logic signed [15:0] bv [8] = '{16'sd1, 16'sd2, 16'sh8000, 16'sd1,
                                       16'sh8000, -16'sd1, 16'sd2, 16'sh8000};
        logic signed [31:0] ev [8] = '{32'sd32767, 32'sd65534, -32'sd32768, -32'sd32768,
                                       32'sd32768, 32'sd32768, -32'sd65536, -32'sd65536};
        logic signed [31:0] p;
        int lat;
        for (int i = 0; i < 8; i++) begin
            do_op(av[i], bv[i], p, lat);
            checks++;
            if (p !== ev[i] || lat !== 16) begin
                errors++;
                $display("FAIL edge[%0d]: out=%0d lat=%0d expected out=%0d lat=16", i, p, lat, ev[i]);
            end
        end
        do_op(16'sh8000, 16'sh8000, p, lat);
        checks++;
        if (p !== 32'sd1073741824) begin
            errors++;
            $display("FAIL edge_minmin: out=%0d expected 1073741824", p);
        end
    endtask

    task automatic test_large();
        logic signed [15:0] av [3] = '{16'sd1000, 16'sd5000, -16'sd10000};
        logic signed [15:0] bv [3] = '{16'sd1000, 16'sd6, 16'sd3};
        logic signed [31:0] ev [3] = '{32'sd1000000, 32'sd30000, -32'sd30000};
        logic signed [31:0] p;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], bv[i], p, lat);
            checks++;
            if (p !== ev[i] || lat !== 16) begin
                errors++;
                $display("FAIL large[%0d]: out=%0d lat=%0d expected out=%0d lat=16", i, p, lat, ev[i]);
            end
        end
    endtask

    task automatic test_operand_change();
        int lat;
        @(negedge clk);
        in1   = 16'sd7;
        in2   = -16'sd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            if (lat == 2) begin
                in1 = 16'sd1234;
                in2 = -16'sd999;
            end
            start = (lat == 4);
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        checks++;
        if (out !== -32'sd63 || lat !== 16) begin
            errors++;
            $display("FAIL operand_change: out=%0d lat=%0d expected out=-63 lat=16", out, lat);
        end
    endtask

    task automatic test_held_start();
        int lat;
        @(negedge clk);
        in1   = -16'sd7;
        in2   = 16'sd11;
        start = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (out !== -32'sd77 || lat !== 16) begin
            errors++;
            $display("FAIL held_first: out=%0d lat=%0d expected out=-77 lat=16", out, lat);
        end
        @(negedge clk);
        in1 = 16'sd3;
        in2 = 16'sd3;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || out !== -32'sd77) begin
            errors++;
            $display("FAIL held_restart: done=%b out=%0d expected done=0 out=-77", done, out);
        end
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (out !== 32'sd9 || lat !== 16) begin
            errors++;
            $display("FAIL held_second: out=%0d lat=%0d expected out=9 lat=16", out, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [31:0] p;
        int lat;
        do_op(16'sd21, -16'sd3, p, lat);
        @(negedge clk);
        in1   = 16'sd40;
        in2   = 16'sd40;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || out !== -32'sd63) begin
            errors++;
            $display("FAIL b2b_accept: done=%b out=%0d expected done=0 out=-63", done, out);
        end
        lat = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (out !== -32'sd63 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold_mid: out=%0d done=%b expected out=-63 done=0", out, done);
        end
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (out !== 32'sd1600 || lat !== 16) begin
            errors++;
            $display("FAIL b2b_second: out=%0d lat=%0d expected out=1600 lat=16", out, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic signed [31:0] p;
        int lat;
        do_op(16'sd100, 16'sd7, p, lat);
        checks++;
        if (p !== 32'sd700) begin
            errors++;
            $display("FAIL rstmid_pre: out=%0d expected 700", p);
        end
        @(negedge clk);
        in1   = 16'sd9;
        in2   = -16'sd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out !== 32'sd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: out=%0d done=%b expected out=0 done=0", out, done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (out !== 32'sd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_quiet: out=%0d done=%b expected out=0 done=0", out, done);
        end
        do_op(-16'sd123, 16'sd45, p, lat);
        checks++;
        if (p !== -32'sd5535 || lat !== 16) begin
            errors++;
            $display("FAIL rstmid_next: out=%0d lat=%0d expected out=-5535 lat=16", p, lat);
        end
    endtask

    task automatic test_random();
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic signed [31:0] exp_p;
        logic signed [31:0] p;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            a     = 16'($urandom);
            b     = 16'($urandom);
            exp_p = a * b;
            do_op(a, b, p, lat);
            checks++;
            if (p !== exp_p || lat !== 16) begin
                errors++;
                $display("FAIL random[%0d] %0d*%0d: out=%0d lat=%0d expected out=%0d lat=16",
                         i, a, b, p, lat, exp_p);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_signed();
        test_edges();
        test_large();
        test_operand_change();
        test_held_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
